pid_pwm: RTL and testbench
==========================

# pid_pwm

Downstream stage of the PID controller. Captures each new controller output `u(n)` (`o_un`/`o_valid` of the PID block), scales and clamps it to a duty count, and drives a single-channel PWM. The new duty is applied glitch-free at the next PWM period boundary. It also emits per-period status for the system wrapper.

## Interface
Parameters:
- `cnt_nb`, 12: width of the period/duty counter.
- `shift`, 8: arithmetic right shift applied to `u(n)` before clamping.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset. Synchronous and active-high.
- `i_un`, in, 32: signed `u(n)` from the PID block.
- `i_valid`, in, 1: PID valid. The rising edge marks a new `i_un`.
- `i_period`, in, `cnt_nb`: PWM period in clocks. Sampled only at a period boundary.
- `i_en`, in, 1: output enable. Sampled only at a period boundary.
- `o_pwm`, out, 1: PWM output.
- `o_duty`, out, `cnt_nb`: duty currently applied (`duty_act`).
- `o_period_start`, out, 1: one-cycle pulse at the start of each period.
- `o_sat_hi`, out, 1: last captured sample was clipped high.
- `o_sat_lo`, out, 1: last captured sample was clipped low (negative).

## Operation
- **Edge detect**
  - `valid_d` is a registered copy of `i_valid`.
  - `cap = i_valid & ~valid_d`.
  - A level held high produces exactly one capture.
- **Stage 1**: on `cap`, `un_q <= i_un`, and `s1_v <= 1`. Otherwise `s1_v <= 0`.
- **Stage 2**: when `s1_v`:
  - `sh = un_q >>> shift` (signed, 32-bit).
  - If `sh < 0`: `duty_pend = 0`, `o_sat_lo = 1`, `o_sat_hi = 0`.
  - Else if `sh > 2^cnt_nb - 1`: `duty_pend = 2^cnt_nb - 1`, `o_sat_hi = 1`, `o_sat_lo = 0`.
  - Else: `duty_pend = sh[cnt_nb-1:0]`, both flags 0.
  - Flags hold until the next stage-2 update.
- **Period counter**
  - `wrap = (period_act == 0) | (cnt == period_act - 1)`.
  - On `wrap`:
    - `cnt <= 0`
    - `period_act <= i_period`
    - `en_act <= i_en`
    - `duty_act <= min(duty_pend, i_period)`
  - Otherwise `cnt <= cnt + 1`.
- **Output**
  - `o_pwm = en_act & (cnt < duty_act)`, decoded from registers only.
  - `duty_act == period_act` gives a constant high. `duty_act == 0` gives a constant low.
- **Period start**: `o_period_start <= wrap & (i_period != 0)`, registered.
- **Zero period**: `period_act == 0` means idle.
  - `wrap` is asserted every cycle and `cnt` stays 0.
  - Duty is clamped to 0, so `o_pwm` is 0.
  - A nonzero `i_period` takes effect at the next edge.
- **Repeated duty**: `duty_pend` is persistent. It is reapplied, re-clamped to the new period, at every wrap until replaced.

## Timing
- **Reset**: at the first `i_clk` edge with `i_rst` high, all of the following are cleared:
  - `valid_d = 0`, `un_q = 0`, `s1_v = 0`, `duty_pend = 0`
  - `cnt = 0`, `period_act = 0`, `duty_act = 0`, `en_act = 0`
  - `o_pwm = 0`, `o_duty = 0`, `o_period_start = 0`, `o_sat_hi = 0`, `o_sat_lo = 0`
  
  Reset mid-period or mid-pipeline discards the in-flight sample. After release, the first edge reloads the period because `period_act == 0`.
- **Capture latency**
  - Edge E0 samples `i_valid = 1` with `valid_d = 0`, and `un_q` loads at E0.
  - `duty_pend` and the saturation flags load at E1.
  - The value is applied at the first `wrap` edge at or after E2.
  - Worst-case visibility on `o_pwm` is 2 + `period_act` cycles.
- **Simultaneous capture and wrap**: a `wrap` at E1 uses the old `duty_pend`. The new value waits for the next wrap.
- **Back-to-back edges**: each edge overwrites the pipeline. Only the latest `duty_pend` at a wrap is applied; intermediate values may be dropped.
- **Period and enable changes**: `i_period` and `i_en` changes mid-period have no effect until the wrap.
- **Counter range**: `cnt` never exceeds `period_act - 1`. There is no wrap-around at `2^cnt_nb`.

## Test plan
1. **Reset.** Drive `i_period = 100`, `i_en = 1`, `i_un = 0x0000_3200` (`shift = 8`, giving 50) with a valid edge.
   - `o_period_start` pulses every 100 cycles.
   - `o_pwm` is high for 50 cycles per period after the first post-capture wrap.
   - `o_duty = 50`.
2. **Saturation.**
   - `i_un = 0xFFFF_F000`: `o_sat_lo = 1`, `o_duty = 0`, `o_pwm` stays low.
   - `i_un = 0x7FFF_FFFF` with `i_period = 100`: `o_sat_hi = 1`, `o_duty = 100`, `o_pwm` is constant high.
3. **Boundary-only update.** Change `i_un` (duty 20 → 80) at `cnt = 30`.
   - The current period finishes at duty 20.
   - The next period starts at 80, with no short or double pulse.
   - Change `i_period` from 100 to 60 mid-period: the old period completes, then duty 80 is clamped to 60.
4. **Valid level and period 0.**
   - Hold `i_valid` high for 500 cycles while `i_un` changes: only the first value is captured.
   - Set `i_period = 0`: `o_pwm = 0`, `cnt = 0`, and `o_period_start` stays 0.
5. **Simultaneous capture and wrap.** Time E1 to coincide with `wrap`. The old duty is applied for that period; the new duty is applied one period later.
6. **Reset mid-operation.** Assert `i_rst` for 1 cycle at `cnt = 40` with `s1_v = 1`.
   - All outputs are 0 on the next cycle.
   - The captured sample is lost.
   - Operation restarts at `cnt = 0` with the current `i_period`.

Source files
------------

// File: rtl/pid_pwm.sv
// PID-to-PWM stage: edge-captures u(n), scales and clamps it to a duty count,
// and applies it glitch-free at PWM period boundaries with per-period status.
module pid_pwm #(
    parameter int unsigned cnt_nb = 12,
    parameter int unsigned shift  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_un,
    input  logic              i_valid,
    input  logic [cnt_nb-1:0] i_period,
    input  logic              i_en,
    output logic              o_pwm,
    output logic [cnt_nb-1:0] o_duty,
    output logic              o_period_start,
    output logic              o_sat_hi,
    output logic              o_sat_lo
);
    localparam int unsigned UN_W = 32;

    logic                   valid_q, valid_d;
    logic [UN_W-1:0]        un_q, un_d;
    logic                   s1_v_q, s1_v_d;
    logic [cnt_nb-1:0]      duty_pend_q, duty_pend_d;
    logic                   sat_hi_q, sat_hi_d;
    logic                   sat_lo_q, sat_lo_d;
    logic [cnt_nb-1:0]      cnt_q, cnt_d;
    logic [cnt_nb-1:0]      period_act_q, period_act_d;
    logic [cnt_nb-1:0]      duty_act_q, duty_act_d;
    logic                   en_act_q, en_act_d;
    logic                   period_start_q, period_start_d;

    logic                   cap;
    logic                   wrap;
    logic signed [UN_W-1:0] sh;

    // Next-state: capture pipeline, clamp stage and period counter.
    always_comb begin
        valid_d        = i_valid;
        un_d           = un_q;
        s1_v_d         = 1'b0;
        duty_pend_d    = duty_pend_q;
        sat_hi_d       = sat_hi_q;
        sat_lo_d       = sat_lo_q;
        cnt_d          = cnt_q + cnt_nb'(1);
        period_act_d   = period_act_q;
        duty_act_d     = duty_act_q;
        en_act_d       = en_act_q;

        cap  = i_valid & ~valid_q;
        sh   = $signed(un_q) >>> shift;
        wrap = (period_act_q == '0) | (cnt_q == period_act_q - cnt_nb'(1));

        if (cap) begin
            un_d   = i_un;
            s1_v_d = 1'b1;
        end

        // Negative values clip to 0; anything beyond the counter range clips to all-ones.
        if (s1_v_q) begin
            if (sh[UN_W-1]) begin
                duty_pend_d = '0;
                sat_lo_d    = 1'b1;
                sat_hi_d    = 1'b0;
            end else if (|sh[UN_W-2:cnt_nb]) begin
                duty_pend_d = '1;
                sat_hi_d    = 1'b1;
                sat_lo_d    = 1'b0;
            end else begin
                duty_pend_d = sh[cnt_nb-1:0];
                sat_hi_d    = 1'b0;
                sat_lo_d    = 1'b0;
            end
        end

        // Period, enable and duty only change at the boundary; duty never exceeds the period.
        if (wrap) begin
            cnt_d        = '0;
            period_act_d = i_period;
            en_act_d     = i_en;
            duty_act_d   = (duty_pend_q > i_period) ? i_period : duty_pend_q;
        end

        period_start_d = wrap & (i_period != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q        <= 1'b0;
            un_q           <= '0;
            s1_v_q         <= 1'b0;
            duty_pend_q    <= '0;
            sat_hi_q       <= 1'b0;
            sat_lo_q       <= 1'b0;
            cnt_q          <= '0;
            period_act_q   <= '0;
            duty_act_q     <= '0;
            en_act_q       <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            un_q           <= un_d;
            s1_v_q         <= s1_v_d;
            duty_pend_q    <= duty_pend_d;
            sat_hi_q       <= sat_hi_d;
            sat_lo_q       <= sat_lo_d;
            cnt_q          <= cnt_d;
            period_act_q   <= period_act_d;
            duty_act_q     <= duty_act_d;
            en_act_q       <= en_act_d;
            period_start_q <= period_start_d;
        end
    end

    // PWM decoded purely from registers so it cannot glitch on input changes.
    assign o_pwm          = en_act_q & (cnt_q < duty_act_q);
    assign o_duty         = duty_act_q;
    assign o_period_start = period_start_q;
    assign o_sat_hi       = sat_hi_q;
    assign o_sat_lo       = sat_lo_q;

endmodule

// File: tb/tb_pid_pwm.sv
// Bench for pid_pwm: random and directed stimulus checked every cycle against
// a reference model built from the period/duty rules with plain integer arithmetic.
module tb_pid_pwm;
    localparam int unsigned CNT_NB = 12;
    localparam int          DMAX   = 4095;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [31:0]       i_un;
    logic              i_valid;
    logic [CNT_NB-1:0] i_period;
    logic              i_en;
    logic              o_pwm;
    logic [CNT_NB-1:0] o_duty;
    logic              o_period_start;
    logic              o_sat_hi;
    logic              o_sat_lo;

    int n_cmp = 0;
    int n_err = 0;

    pid_pwm #(.cnt_nb(CNT_NB), .shift(8)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_un           (i_un),
        .i_valid        (i_valid),
        .i_period       (i_period),
        .i_en           (i_en),
        .o_pwm          (o_pwm),
        .o_duty         (o_duty),
        .o_period_start (o_period_start),
        .o_sat_hi       (o_sat_hi),
        .o_sat_lo       (o_sat_lo)
    );

    always #5 i_clk = ~i_clk;

    // Reference model state
    bit     m_vprev, m_s1, m_hi, m_lo, m_en, m_ps;
    longint m_un;
    int     m_pend, m_cnt, m_per, m_dact;

    // u(n)/256 rounded toward minus infinity, then clipped to [0, 4095].
    function automatic void clamp(input longint un, output int d, output bit hi, output bit lo);
        longint sh;
        if (un >= 0) sh = un / 256;
        else         sh = -((-un + 255) / 256);
        hi = 1'b0;
        lo = 1'b0;
        if (sh < 0)         begin d = 0;    lo = 1'b1; end
        else if (sh > DMAX) begin d = DMAX; hi = 1'b1; end
        else                d = int'(sh);
    endfunction

    task automatic model_edge();
        bit wrap, cap;
        int per_in;
        if (i_rst) begin
            m_vprev = 0; m_s1 = 0; m_hi = 0; m_lo = 0; m_en = 0; m_ps = 0;
            m_un = 0; m_pend = 0; m_cnt = 0; m_per = 0; m_dact = 0;
            return;
        end
        per_in = int'(i_period);
        wrap   = (m_per == 0) || (m_cnt == m_per - 1);
        cap    = i_valid && !m_vprev;
        if (wrap) begin
            m_cnt  = 0;
            m_per  = per_in;
            m_en   = i_en;
            m_dact = (m_pend > per_in) ? per_in : m_pend;
        end else begin
            m_cnt = m_cnt + 1;
        end
        m_ps = wrap && (per_in != 0);
        if (m_s1) clamp(m_un, m_pend, m_hi, m_lo);
        m_s1 = cap;
        if (cap) m_un = longint'($signed(i_un));
        m_vprev = i_valid;
    endtask

    function automatic logic [15:0] exp_vec();
        return {(m_en && (m_cnt < m_dact)), 12'(m_dact), m_ps, m_hi, m_lo};
    endfunction

    task automatic cycle();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
    endtask

    task automatic pulse(input logic [31:0] un);
        i_un    = un;
        i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (m_cnt != target && n < 5000) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (m_cnt != target) begin
            n_err++;
            $display("FAIL wait_cnt: cnt %0d never reached %0d", m_cnt, target);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_un = '0; i_period = 12'd100; i_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++;
            if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== 16'h0) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %h exp 0000", k,
                         {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo});
            end
        end
        i_rst = 1'b0;
    endtask

    task automatic test_basic();
        int starts = 0, highs = 0, n = 0;
        pulse(32'h0000_3200);
        for (int k = 0; k < 400; k++) begin
            cycle();
            if (k >= 100) starts += int'(o_period_start);
            n_cmp++;
            if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                n_err++;
                $display("FAIL basic cyc %0d: got %h exp %h", k,
                         {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo}, exp_vec());
            end
        end
        n_cmp++;
        if (starts != 3) begin n_err++; $display("FAIL basic_starts: got %0d exp 3", starts); end
        while (!o_period_start && n < 200) begin cycle(); n++; end
        for (int k = 0; k < 100; k++) begin highs += int'(o_pwm); cycle(); end
        n_cmp++;
        if (highs != 50) begin n_err++; $display("FAIL basic_highs: got %0d exp 50", highs); end
        n_cmp++;
        if (o_duty !== 12'd50) begin n_err++; $display("FAIL basic_duty: got %0d exp 50", o_duty); end
    endtask

    task automatic test_saturation();
        int highs;
        for (int t = 0; t < 2; t++) begin
            highs = 0;
            pulse(t == 0 ? 32'hFFFF_F000 : 32'h7FFF_FFFF);
            for (int k = 0; k < 300; k++) begin
                cycle();
                if (k >= 200) highs += int'(o_pwm);
                n_cmp++;
                if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                    n_err++;
                    $display("FAIL sat%0d cyc %0d: got %h exp %h", t, k,
                             {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo}, exp_vec());
                end
            end
            n_cmp++;
            if (t == 0 && (o_sat_lo !== 1'b1 || o_sat_hi !== 1'b0 || o_duty !== 12'd0 || highs != 0)) begin
                n_err++;
                $display("FAIL sat_lo: got lo=%b hi=%b duty=%0d highs=%0d exp 1 0 0 0",
                         o_sat_lo, o_sat_hi, o_duty, highs);
            end
            if (t == 1 && (o_sat_hi !== 1'b1 || o_sat_lo !== 1'b0 || o_duty !== 12'd100 || highs != 100)) begin
                n_err++;
                $display("FAIL sat_hi: got hi=%b lo=%b duty=%0d highs=%0d exp 1 0 100 100",
                         o_sat_hi, o_sat_lo, o_duty, highs);
            end
        end
    endtask

    task automatic test_boundary();
        int n, highs;
        pulse(32'h0000_1400);
        for (int k = 0; k < 250; k++) cycle();
        wait_cnt(29);
        pulse(32'h0000_5000);
        n = 0; highs = 0;
        do begin
            highs += int'(o_pwm);
            cycle(); n++;
            n_cmp++;
            if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                n_err++;
                $display("FAIL bound cyc %0d: got %h exp %h", n,
                         {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo}, exp_vec());
            end
        end while (!o_period_start && n < 300);
        n_cmp++;
        if (o_duty !== 12'd80 || highs != 0 || n != 70) begin
            n_err++;
            $display("FAIL bound_switch: got duty=%0d tail_highs=%0d len=%0d exp 80 0 70", o_duty, highs, n);
        end
        wait_cnt(50);
        i_period = 12'd60;
        n = 0;
        do begin
            cycle(); n++;
            n_cmp++;
            if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                n_err++;
                $display("FAIL bound_per cyc %0d: got %h exp %h", n,
                         {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo}, exp_vec());
            end
        end while (!o_period_start && n < 300);
        n_cmp++;
        if (n != 50 || o_duty !== 12'd60) begin
            n_err++;
            $display("FAIL bound_period: got len=%0d duty=%0d exp 50 60", n, o_duty);
        end
        highs = 0;
        for (int k = 0; k < 60; k++) begin highs += int'(o_pwm); cycle(); end
        n_cmp++;
        if (highs != 60) begin n_err++; $display("FAIL bound_full: got %0d exp 60", highs); end
        i_period = 12'd100;
    endtask

    task automatic test_valid_level();
        logic [31:0] first;
        int d, ex;
        bit hi, lo;
        first = 32'($urandom_range(0, 32'h000F_FFFF));
        i_un = first;
        i_valid = 1'b1;
        for (int k = 0; k < 650; k++) begin
            cycle();
            if (k < 500) i_un = $urandom;
            else         i_valid = 1'b0;
            n_cmp++;
            if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                n_err++;
                $display("FAIL level cyc %0d: got %h exp %h", k,
                         {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo}, exp_vec());
            end
        end
        clamp(longint'($signed(first)), d, hi, lo);
        ex = (d > 100) ? 100 : d;
        n_cmp++;
        if (int'(o_duty) != ex) begin n_err++; $display("FAIL level_duty: got %0d exp %0d", o_duty, ex); end
        i_period = 12'd0;
        for (int k = 0; k < 120; k++) cycle();
        for (int k = 0; k < 200; k++) begin
            cycle();
            n_cmp++;
            if (o_pwm !== 1'b0 || o_period_start !== 1'b0 || o_duty !== 12'd0
                || m_cnt != 0 || {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                n_err++;
                $display("FAIL idle cyc %0d: got pwm=%b ps=%b duty=%0d exp 0 0 0", k,
                         o_pwm, o_period_start, o_duty);
            end
        end
        i_period = 12'd100;
    endtask

    task automatic test_simul_wrap();
        pulse(32'h0000_1E00);
        for (int k = 0; k < 250; k++) cycle();
        wait_cnt(98);
        pulse(32'h0000_4600);
        cycle();
        n_cmp++;
        if (o_period_start !== 1'b1 || o_duty !== 12'd30) begin
            n_err++;
            $display("FAIL simul_old: got ps=%b duty=%0d exp 1 30", o_period_start, o_duty);
        end
        for (int k = 0; k < 100; k++) begin
            cycle();
            n_cmp++;
            if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                n_err++;
                $display("FAIL simul cyc %0d: got %h exp %h", k,
                         {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo}, exp_vec());
            end
        end
        n_cmp++;
        if (o_period_start !== 1'b1 || o_duty !== 12'd70) begin
            n_err++;
            $display("FAIL simul_new: got ps=%b duty=%0d exp 1 70", o_period_start, o_duty);
        end
    endtask

    task automatic test_reset_mid();
        wait_cnt(39);
        pulse(32'h0000_6400);
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        n_cmp++;
        if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== 16'h0) begin
            n_err++;
            $display("FAIL rst_mid: got %h exp 0000", {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo});
        end
        for (int k = 0; k < 300; k++) begin
            cycle();
            n_cmp++;
            if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                n_err++;
                $display("FAIL rst_after cyc %0d: got %h exp %h", k,
                         {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo}, exp_vec());
            end
        end
        n_cmp++;
        if (o_duty !== 12'd0) begin n_err++; $display("FAIL rst_lost: got duty=%0d exp 0", o_duty); end
    endtask

    task automatic test_random();
        logic [31:0] un;
        int per;
        for (int t = 0; t < 10; t++) begin
            case (t)
                0: un = 32'h000F_FF00;
                1: un = 32'h0010_0000;
                2: un = 32'hFFFF_FFFF;
                default: un = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h000F_FFFF));
            endcase
            per = (t == 3) ? 1 : ((t < 2) ? 4095 : $urandom_range(1, 200));
            i_period = 12'(per);
            i_en = ($urandom_range(0, 3) != 0);
            pulse(un);
            for (int k = 0; k < ((per > 300) ? 600 : 2 * per + 30); k++) begin
                cycle();
                if ($urandom_range(0, 40) == 0) i_valid = ~i_valid;
                n_cmp++;
                if ({o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo} !== exp_vec()) begin
                    n_err++;
                    $display("FAIL rand%0d cyc %0d: got %h exp %h", t, k,
                             {o_pwm, o_duty, o_period_start, o_sat_hi, o_sat_lo}, exp_vec());
                end
            end
            i_valid = 1'b0;
            cycle();
        end
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_un = '0; i_period = '0; i_en = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_boundary();
        test_valid_level();
        test_simul_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
